button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Per-channel debouncer and event generator for push-buttons and switches.
- Consumes the already-synchronized outputs of the switch/button synchronizer stage, one bit per channel.
- Produces per channel: a clean debounced level, one-cycle press pulses (with optional auto-repeat while held), and one-cycle release pulses.
- Feeds control FSMs such as Run, ClearA_LoadB and Reset_Load in the lab top levels.

Parameters:
- N, 4, number of independent channels (1..16).
- ACTIVE_LOW, 1, 1 = din low means pressed (DE2 KEYs); 0 = din high means pressed; applies to all channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a change; legal range 2..2^24.
- REPEAT_EN, 0, 1 = generate auto-repeat press pulses while held.
- REPEAT_DELAY, 25000000, cycles from the initial press pulse to the first repeat pulse; must be >= 2.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses; must be >= 2.

Ports:
- Clk, input, 1, system clock; all state is updated on posedge.
- Reset, input, 1, asynchronous, active-high reset.
- din, input, N, synchronized raw inputs; not re-synchronized inside this block.
- level, output, N, debounced state; 1 = pressed, regardless of ACTIVE_LOW.
- press, output, N, one-cycle pulse on accepted press and on each auto-repeat.
- release, output, N, one-cycle pulse on accepted release.
- any_pressed, output, 1, OR of level.

Behaviour:
- Normalized input: p[i] = din[i] XOR ACTIVE_LOW.
- Channels are fully independent. Each channel has a 4-state FSM, a debounce counter sized by $clog2(DEBOUNCE_CYCLES), and a repeat counter sized for the larger of the two repeat constants.
- Reset (asynchronous, immediate): FSM = IDLE; counters = 0; level, press, release, any_pressed = 0. Reset mid-debounce or mid-hold discards all progress; no pulse is emitted on reset.
- After reset release, every channel starts in IDLE. If p is already 1, this counts as a fresh press: full debounce, then a press pulse.
- IDLE (level=0):
  - p=1 -> PRESS_WAIT, counter=1.
  - p=0 -> stay.
- PRESS_WAIT (level=0):
  - p=0 -> IDLE, counter=0 (bounce rejected, no pulse).
  - p=1 and counter==DEBOUNCE_CYCLES-1 -> HELD; level<=1; press<=1; repeat counter=0.
  - Otherwise counter+1.
- Net latency: level and press are registered and both go high in the cycle after the DEBOUNCE_CYCLES-th consecutive posedge sampling p=1.
- HELD (level=1):
  - p=0 -> RELEASE_WAIT, counter=1; repeat counter frozen.
  - p=1: repeat counter advances only if REPEAT_EN. press<=1 when it reaches REPEAT_DELAY-1 (first repeat), then every REPEAT_RATE cycles after that; the counter reloads accordingly.
- RELEASE_WAIT (level=1):
  - p=1 -> HELD; no press pulse; repeat counter resumes from its frozen value.
  - p=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; level<=0; release<=1.
  - Otherwise counter+1.
- Pulse rules:
  - press and release are high for exactly 1 cycle per event and are never high together on a channel.
  - Pulses on different channels may coincide.
- Glitch filtering: a glitch shorter than DEBOUNCE_CYCLES in either direction produces no change on level, press or release.
- Counters saturate and never wrap. There is no state from which a counter can overrun its compare value.
- any_pressed is the registered OR of the next-state level bits, so it changes in the same cycle as level.
- REPEAT_EN=0: the repeat logic is removed and only the initial press pulse is generated.

Test Plan:
Bench parameters: N=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset with din=2'b11, hold for 20 cycles -> level=0, press=0, release=0 throughout; assert Reset mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
- din[0]=0 held -> level[0] and press[0] rise the cycle after the 4th sampling edge; press[0] lasts 1 cycle; any_pressed=1.
- din[0] low for 3 cycles, then high -> no level/press change. Then held low, with a 2-cycle high glitch after acceptance -> level[0] stays 1, no release, no extra press.
- Release din[0] for 4 cycles -> release[0] pulses 1 cycle, level[0]=0, any_pressed=0.
- REPEAT_EN=1, din[1] held low for 25 cycles after press -> press[1] pulses at relative cycles 0, 10, 13, 16, 19, 22.
- Both channels pressed on the same edge -> identical press timing on both; release ch0 only -> ch1 level unaffected.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//
// Per-channel debouncer and event generator for push-buttons and switches.
// Takes the already-synchronized button/switch bits and produces, per
// channel, a clean debounced level plus one-cycle press and release pulses.
// Optionally generates auto-repeat press pulses while a button is held.
//
// Ports:
//   Clk           - system clock, all state updates on posedge
//   Reset         - asynchronous, active-high reset
//   din[N]        - synchronized raw inputs (no extra synchronization here)
//   level[N]      - debounced state, 1 = pressed regardless of ACTIVE_LOW
//   press[N]      - one-cycle pulse on accepted press and on each auto-repeat
//   release_pulse[N] - one-cycle pulse on accepted release
//   any_pressed   - OR of all level bits, updated in the same cycle as level
//
// Parameters:
//   N               - number of independent channels (1..16)
//   ACTIVE_LOW      - 1: din low means pressed; 0: din high means pressed
//   DEBOUNCE_CYCLES - consecutive stable samples needed to accept a change
//   REPEAT_EN       - 1: auto-repeat press pulses while held
//   REPEAT_DELAY    - cycles from the initial press pulse to the first repeat
//   REPEAT_RATE     - cycles between subsequent repeat pulses
module button_conditioner #(
    parameter int N               = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic         any_pressed
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [N-1:0] level_nx;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan

        state_t        st, st_nx;
        logic [DW-1:0] dcnt, dcnt_nx;
        logic [RW-1:0] rcnt, rcnt_nx;
        logic          rep, rep_nx;
        logic          lvl_r, press_r, rel_r;
        logic          press_nx, rel_nx;
        logic          p;

        // Normalize polarity so that p = 1 always means "pressed".
        assign p = din[gi] ^ (ACTIVE_LOW != 0);

        // Next-state logic. The debounce counter counts consecutive samples
        // that disagree with the accepted level; it never exceeds DEB_LAST
        // because reaching it always moves the FSM to another state. The
        // repeat counter compares against the initial delay until the first
        // repeat has fired (rep = 0), then against the repeat rate; it is
        // reloaded to zero on every hit, so it never runs past its compare
        // value. It is frozen while waiting out a possible release so a short
        // release glitch does not restart the repeat timing.
        always_comb begin
            st_nx    = st;
            dcnt_nx  = dcnt;
            rcnt_nx  = rcnt;
            rep_nx   = rep;
            press_nx = 1'b0;
            rel_nx   = 1'b0;
            case (st)
                IDLE: begin
                    if (p) begin
                        st_nx   = PRESS_WAIT;
                        dcnt_nx = DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        st_nx   = IDLE;
                        dcnt_nx = '0;
                    end else if (dcnt == DEB_LAST) begin
                        st_nx    = HELD;
                        dcnt_nx  = '0;
                        press_nx = 1'b1;
                        rcnt_nx  = '0;
                        rep_nx   = 1'b0;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!p) begin
                        st_nx   = RELEASE_WAIT;
                        dcnt_nx = DW'(1);
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt == (rep ? RATE_LAST : DELAY_LAST)) begin
                            press_nx = 1'b1;
                            rcnt_nx  = '0;
                            rep_nx   = 1'b1;
                        end else begin
                            rcnt_nx = rcnt + RW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        st_nx   = HELD;
                        dcnt_nx = '0;
                    end else if (dcnt == DEB_LAST) begin
                        st_nx   = IDLE;
                        dcnt_nx = '0;
                        rel_nx  = 1'b1;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                default: begin
                    st_nx   = IDLE;
                    dcnt_nx = '0;
                end
            endcase
        end

        // The level follows the next state directly so that level and the
        // press/release pulse change in the same cycle.
        assign level_nx[gi] = (st_nx == HELD) || (st_nx == RELEASE_WAIT);

        // State and output registers; reset drops everything immediately.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                st      <= IDLE;
                dcnt    <= '0;
                rcnt    <= '0;
                rep     <= 1'b0;
                lvl_r   <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                st      <= st_nx;
                dcnt    <= dcnt_nx;
                rcnt    <= rcnt_nx;
                rep     <= rep_nx;
                lvl_r   <= level_nx[gi];
                press_r <= press_nx;
                rel_r   <= rel_nx;
            end
        end

        assign level[gi]         = lvl_r;
        assign press[gi]         = press_r;
        assign release_pulse[gi] = rel_r;
    end

    // Registered OR of the next-state levels, so it tracks level exactly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |level_nx;
        end
    end

endmodule
